// File: rtl/prelu_backward.sv
// Two-stage streaming PReLU backward unit: dx = x<0 ? dy>>>alpha : dy, plus a per-frame sum of x*dy over negative x.
// Optional accumulator saturation with overflow reporting is enabled by defining PRELU_BWD_SAT_EN.
`timescale 1ns/1ps
module prelu_backward #(
    parameter int WIDTH       = 8,
    parameter int ALPHA_WIDTH = 8,
    parameter int FRAME_LEN   = 64,
    parameter int ACC_WIDTH   = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       x_in,
    input  logic [WIDTH-1:0]       dy_in,
    input  logic [ALPHA_WIDTH-1:0] alpha,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       dx_out,
    output logic                   acc_valid,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_ovf
);

    localparam int PW    = 2 * WIDTH;
    localparam int SH_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = $clog2(FRAME_LEN);

    logic                        s1_valid_q, s1_valid_d;
    logic        [WIDTH-1:0]     s1_x_q, s1_x_d;
    logic signed [WIDTH-1:0]     s1_dy_q, s1_dy_d;
    logic                        s1_neg_q, s1_neg_d;
    logic        [SH_W-1:0]      s1_shift_q, s1_shift_d;
    logic signed [PW-1:0]        s1_prod_q, s1_prod_d;
    logic                        out_valid_q, out_valid_d;
    logic        [WIDTH-1:0]     dx_q, dx_d;
    logic        [CNT_W-1:0]     cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        ovf_q, ovf_d;
    logic        [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
    logic                        acc_ovf_q, acc_ovf_d;
    logic                        acc_valid_q, acc_valid_d;

    logic                        stall_s;
    logic signed [WIDTH-1:0]     dy_sh_s;
    logic signed [ACC_WIDTH-1:0] acc_next_s;
    logic                        ovf_next_s;

`ifdef PRELU_BWD_SAT_EN
    // Returns {clamped, sum}; the sum is pinned to the signed limits on overflow.
    function automatic logic [ACC_WIDTH:0] sat_add(input logic signed [ACC_WIDTH-1:0] a,
                                                   input logic signed [PW-1:0] b);
        logic signed [ACC_WIDTH:0] s;
        s = (ACC_WIDTH+1)'(a) + (ACC_WIDTH+1)'(b);
        if (s[ACC_WIDTH] != s[ACC_WIDTH-1]) begin
            if (s[ACC_WIDTH]) sat_add = {1'b1, 1'b1, {(ACC_WIDTH-1){1'b0}}};
            else              sat_add = {1'b1, 1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            sat_add = {1'b0, s[ACC_WIDTH-1:0]};
        end
    endfunction
`endif

    assign stall_s   = out_valid_q && !out_ready;
    assign in_ready  = !stall_s && !reset;
    assign dy_sh_s   = s1_dy_q >>> s1_shift_q;
    assign out_valid = out_valid_q;
    assign dx_out    = dx_q;
    assign acc_valid = acc_valid_q;
    assign acc_out   = acc_out_q;
    assign acc_ovf   = acc_ovf_q;

    // Accumulator candidate for the element currently in S1.
    always_comb begin
        acc_next_s = acc_q;
        ovf_next_s = ovf_q;
        if (s1_neg_q) begin
`ifdef PRELU_BWD_SAT_EN
            {ovf_next_s, acc_next_s} = {ovf_q, {ACC_WIDTH{1'b0}}} | sat_add(acc_q, s1_prod_q);
`else
            acc_next_s = acc_q + ACC_WIDTH'(s1_prod_q);
            ovf_next_s = 1'b0;
`endif
        end else begin
            acc_next_s = acc_q;
        end
    end

    // Next-state for both pipeline stages, the frame counter and the frame report.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_x_d      = s1_x_q;
        s1_dy_d     = s1_dy_q;
        s1_neg_d    = s1_neg_q;
        s1_shift_d  = s1_shift_q;
        s1_prod_d   = s1_prod_q;
        out_valid_d = out_valid_q;
        dx_d        = dx_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        acc_out_d   = acc_out_q;
        acc_ovf_d   = acc_ovf_q;
        acc_valid_d = 1'b0;
        if (!stall_s) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_x_d    = x_in;
                s1_dy_d   = $signed(dy_in);
                s1_neg_d  = x_in[WIDTH-1];
                s1_prod_d = $signed(x_in) * $signed(dy_in);
                if (32'(alpha) >= 32'(WIDTH)) s1_shift_d = SH_W'(WIDTH - 1);
                else                          s1_shift_d = SH_W'(alpha);
            end else begin
                s1_x_d = s1_x_q;
            end
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                dx_d = s1_neg_q ? dy_sh_s : s1_dy_q;
                if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                    acc_out_d   = acc_next_s;
                    acc_ovf_d   = ovf_next_s;
                    acc_valid_d = 1'b1;
                    acc_d       = '0;
                    ovf_d       = 1'b0;
                    cnt_d       = '0;
                end else begin
                    acc_d = acc_next_s;
                    ovf_d = ovf_next_s;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                dx_d = dx_q;
            end
        end else begin
            acc_valid_d = 1'b0;
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_dy_q     <= '0;
            s1_neg_q    <= 1'b0;
            s1_shift_q  <= '0;
            s1_prod_q   <= '0;
            out_valid_q <= 1'b0;
            dx_q        <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            ovf_q       <= 1'b0;
            acc_out_q   <= '0;
            acc_ovf_q   <= 1'b0;
            acc_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_dy_q     <= s1_dy_d;
            s1_neg_q    <= s1_neg_d;
            s1_shift_q  <= s1_shift_d;
            s1_prod_q   <= s1_prod_d;
            out_valid_q <= out_valid_d;
            dx_q        <= dx_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
            acc_out_q   <= acc_out_d;
            acc_ovf_q   <= acc_ovf_d;
            acc_valid_q <= acc_valid_d;
        end
    end

endmodule

// File: tb/tb_prelu_backward.sv
// Directed self-checking bench for prelu_backward (one FRAME_LEN=4 instance, one ACC_WIDTH=16/FRAME_LEN=3 instance).
`timescale 1ns/1ps
module tb_prelu_backward;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, acc_valid, acc_ovf;
    logic [7:0]  x_in, dy_in, alpha, dx_out;
    logic [23:0] acc_out;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_acc_valid, b_acc_ovf;
    logic [7:0]  b_x, b_dy, b_alpha, b_dx;
    logic [15:0] b_acc_out;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0]  dxq[$];
    logic [23:0] accq[$];
    int          aidx[$];
    logic        aov[$];
    logic        aovf[$];
    logic [15:0] baccq[$];
    logic        bovfq[$];

    prelu_backward #(.WIDTH(8), .ALPHA_WIDTH(8), .FRAME_LEN(4), .ACC_WIDTH(24)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .dy_in(dy_in), .alpha(alpha), .out_valid(out_valid),
        .out_ready(out_ready), .dx_out(dx_out), .acc_valid(acc_valid),
        .acc_out(acc_out), .acc_ovf(acc_ovf));

    prelu_backward #(.WIDTH(8), .ALPHA_WIDTH(8), .FRAME_LEN(3), .ACC_WIDTH(16)) dut_b (
        .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .x_in(b_x), .dy_in(b_dy), .alpha(b_alpha), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .dx_out(b_dx), .acc_valid(b_acc_valid),
        .acc_out(b_acc_out), .acc_ovf(b_acc_ovf));

    always #5 clk = ~clk;

    // Record every dx transfer and every frame report, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && out_ready) dxq.push_back(dx_out);
            if (acc_valid) begin
                accq.push_back(acc_out);
                aidx.push_back(dxq.size());
                aov.push_back(out_valid);
                aovf.push_back(acc_ovf);
            end
            if (b_acc_valid) begin
                baccq.push_back(b_acc_out);
                bovfq.push_back(b_acc_ovf);
            end
        end
    end

    function automatic logic [7:0] m_dx(input logic [7:0] x, input logic [7:0] dy, input logic [7:0] al);
        logic signed [7:0] t;
        int sh;
        sh = (al > 8'd7) ? 7 : int'(al);
        t  = dy;
        if (x[7]) m_dx = t >>> sh;
        else      m_dx = dy;
    endfunction

    function automatic int m_prod(input logic [7:0] x, input logic [7:0] dy);
        m_prod = x[7] ? int'($signed(x)) * int'($signed(dy)) : 0;
    endfunction

    task automatic clear_q();
        dxq.delete(); accq.delete(); aidx.delete(); aov.delete(); aovf.delete();
        baccq.delete(); bovfq.delete();
    endtask

    task automatic send(input logic [7:0] x, input logic [7:0] dy, input logic [7:0] al);
        bit ok;
        int guard;
        in_valid = 1'b1; x_in = x; dy_in = dy; alpha = al;
        ok = 1'b0; guard = 0;
        while (!ok && guard < 50) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: in_ready never 1 within 50 cycles (x=%h)", x);
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; x_in = 8'h00; dy_in = 8'h00; alpha = 8'h00;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_x = 8'h00; b_dy = 8'h00; b_alpha = 8'h00;
        idle(2);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (dx_out !== 8'h00) begin n_err++; $display("FAIL rst_dx_out: got %h want 00", dx_out); end
        n_cmp++; if (acc_valid !== 1'b0) begin n_err++; $display("FAIL rst_acc_valid: got %b want 0", acc_valid); end
        n_cmp++; if (acc_out !== 24'h0) begin n_err++; $display("FAIL rst_acc_out: got %h want 0", acc_out); end
        n_cmp++; if (acc_ovf !== 1'b0) begin n_err++; $display("FAIL rst_acc_ovf: got %b want 0", acc_ovf); end
        n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_q();
    endtask

    // First frame: single elements with gaps, checking latency and edge cases.
    task automatic test_first_frame();
        send(8'h20, 8'h10, 8'd2);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL lat_early: out_valid %b want 0", out_valid); end
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1 || dx_out !== 8'h10) begin
            n_err++; $display("FAIL lat_nonneg: out_valid %b dx %h want 1/10", out_valid, dx_out); end
        @(posedge clk); #1;
        send(8'hE0, 8'h40, 8'd2);
        send(8'h00, 8'h80, 8'd3);
        send(8'h80, 8'h80, 8'd9);
        idle(4);
        n_cmp++; if (dxq.size() != 4 || dxq[1] !== 8'h10 || dxq[2] !== 8'h80 || dxq[3] !== 8'hFF) begin
            n_err++; $display("FAIL first_dx: count %0d want 4 (neg/zero/clamp dx)", dxq.size()); end
        n_cmp++; if (accq.size() != 1 || accq[0] !== 24'h003800) begin
            n_err++; $display("FAIL first_sum: reports %0d want 1 of 003800", accq.size()); end
        n_cmp++; if (aidx.size() != 1 || aidx[0] != 4 || aov[0] !== 1'b1 || aovf[0] !== 1'b0) begin
            n_err++; $display("FAIL first_pulse_align: not coincident with 4th dx"); end
        clear_q();
    endtask

    task automatic test_frame_sum();
        for (int i = 0; i < 4; i++) send(8'hE0, 8'h20, 8'd1);
        idle(4);
        n_cmp++; if (accq.size() != 1 || accq[0] !== 24'hFFF000) begin
            n_err++; $display("FAIL frame_sum: reports %0d want 1 of FFF000", accq.size()); end
        n_cmp++; if (aidx.size() != 1 || aidx[0] != 4 || aov[0] !== 1'b1) begin
            n_err++; $display("FAIL frame_pulse_align: pulse not with 4th dx"); end
        n_cmp++; if (dxq.size() != 4 || dxq[0] !== 8'h10 || dxq[3] !== 8'h10) begin
            n_err++; $display("FAIL frame_dx: count %0d want 4 of 10", dxq.size()); end
        n_cmp++; if (acc_out !== 24'hFFF000 || acc_valid !== 1'b0) begin
            n_err++; $display("FAIL frame_hold: acc_out %h valid %b want FFF000/0", acc_out, acc_valid); end
        clear_q();
    endtask

    // Back-to-back stream of two frames with a 5-cycle downstream stall.
    task automatic test_back_to_back_stall();
        logic [7:0] xs[8]  = '{8'h10, 8'hF0, 8'h7F, 8'h80, 8'h00, 8'hC0, 8'h05, 8'hFF};
        logic [7:0] dys[8] = '{8'h33, 8'h50, 8'h81, 8'h7F, 8'h90, 8'hA0, 8'h11, 8'h22};
        logic [7:0] als[8] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd20};
        int s0, s1;
        s0 = 0; s1 = 0;
        for (int i = 0; i < 4; i++) s0 += m_prod(xs[i], dys[i]);
        for (int i = 4; i < 8; i++) s1 += m_prod(xs[i], dys[i]);
        fork
            begin
                for (int i = 0; i < 8; i++) send(xs[i], dys[i], als[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
                        n_err++; $display("FAIL stall_%0d: in_ready %b out_valid %b want 0/1", k, in_ready, out_valid); end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        idle(4);
        n_cmp++; if (dxq.size() != 8) begin n_err++; $display("FAIL stall_count: got %0d want 8", dxq.size()); end
        for (int i = 0; i < 8 && i < dxq.size(); i++) begin
            n_cmp++; if (dxq[i] !== m_dx(xs[i], dys[i], als[i])) begin
                n_err++; $display("FAIL stall_dx_%0d: got %h want %h", i, dxq[i], m_dx(xs[i], dys[i], als[i])); end
        end
        n_cmp++; if (accq.size() != 2) begin n_err++; $display("FAIL stall_reports: got %0d want 2", accq.size()); end
        else begin
            n_cmp++; if (accq[0] !== 24'(s0) || accq[1] !== 24'(s1)) begin
                n_err++; $display("FAIL stall_sums: got %h %h want %h %h", accq[0], accq[1], 24'(s0), 24'(s1)); end
        end
        clear_q();
    endtask

    task automatic test_reset_mid_frame();
        send(8'h80, 8'h7F, 8'd0);
        send(8'h80, 8'h7F, 8'd0);
        reset = 1'b1;
        #2;
        n_cmp++; if (out_valid !== 1'b0 || dx_out !== 8'h00 || acc_valid !== 1'b0) begin
            n_err++; $display("FAIL midrst_out: valid %b dx %h accv %b want 0", out_valid, dx_out, acc_valid); end
        n_cmp++; if (acc_out !== 24'h0 || acc_ovf !== 1'b0 || in_ready !== 1'b0) begin
            n_err++; $display("FAIL midrst_acc: acc %h ovf %b rdy %b want 0", acc_out, acc_ovf, in_ready); end
        @(posedge clk); #1;
        reset = 1'b0;
        clear_q();
        for (int i = 0; i < 4; i++) send(8'hE0, 8'h20, 8'd0);
        idle(4);
        n_cmp++; if (accq.size() != 1 || accq[0] !== 24'hFFF000) begin
            n_err++; $display("FAIL midrst_sum: reports %0d want 1 of FFF000", accq.size()); end
        n_cmp++; if (dxq.size() != 4 || dxq[0] !== 8'h20) begin
            n_err++; $display("FAIL midrst_dx: count %0d want 4 of 20", dxq.size()); end
        clear_q();
    endtask

    task automatic test_acc_overflow();
        logic [15:0] exp_sum;
        logic        exp_ovf;
`ifdef PRELU_BWD_SAT_EN
        exp_sum = 16'h7FFF; exp_ovf = 1'b1;
`else
        exp_sum = 16'hC000; exp_ovf = 1'b0;
`endif
        b_in_valid = 1'b1; b_x = 8'h80; b_dy = 8'h80; b_alpha = 8'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (b_in_ready !== 1'b1) begin n_err++; $display("FAIL ovf_ready_%0d: got %b want 1", i, b_in_ready); end
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        idle(4);
        n_cmp++; if (baccq.size() != 1 || baccq[0] !== exp_sum) begin
            n_err++; $display("FAIL ovf_sum: reports %0d want 1 of %h", baccq.size(), exp_sum); end
        n_cmp++; if (bovfq.size() != 1 || bovfq[0] !== exp_ovf) begin
            n_err++; $display("FAIL ovf_flag: want %b", exp_ovf); end
        clear_q();
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_frame_sum();
        test_back_to_back_stall();
        test_reset_mid_frame();
        test_acc_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
